// File: rtl/multi_clk_div.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : multi_clk_div
//  Purpose  : Multi-channel programmable clock-enable generator. Each channel
//             emits a one-cycle tick every D cycles and a 50% square wave of
//             period 2*D. Divisor changes are applied at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_clk_div #(
   parameter int NUM_CH    = 2,
   parameter int CNT_WIDTH = 26
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_en,
   input  logic                        i_sync,
   input  logic [NUM_CH*CNT_WIDTH-1:0] i_div,
   output logic [NUM_CH-1:0]           o_tick,
   output logic [NUM_CH-1:0]           o_wave
);

   localparam logic [CNT_WIDTH-1:0] c_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] c_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
         logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
         logic [CNT_WIDTH-1:0] div_q, div_d;
         logic                 tick_q, tick_d;
         logic                 wave_q, wave_d;
         logic [CNT_WIDTH-1:0] w_div_req;
         logic                 w_term;

         assign w_div_req = i_div[k*CNT_WIDTH +: CNT_WIDTH];
         // Terminal count; only meaningful when the active divisor is non-zero,
         // so the wrap of div_q-1 at zero is never consulted.
         assign w_term    = (cnt_q == (div_q - c_ONE));

         // Next-state selection in priority order: sync, idle, hold, terminal, count.
         always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            tick_d = 1'b0;
            wave_d = wave_q;
            if (i_sync) begin
               cnt_d  = c_ZERO;
               wave_d = 1'b0;
               div_d  = w_div_req;
            end else if (div_q == c_ZERO) begin
               // Idle channel keeps sampling the request so it can start at any time.
               cnt_d  = c_ZERO;
               div_d  = w_div_req;
            end else if (!i_en) begin
               cnt_d  = cnt_q;
            end else if (w_term) begin
               tick_d = 1'b1;
               wave_d = ~wave_q;
               cnt_d  = c_ZERO;
               div_d  = w_div_req;
            end else begin
               cnt_d  = cnt_q + c_ONE;
            end
         end

         // Channel state registers with asynchronous clear.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               cnt_q  <= c_ZERO;
               div_q  <= c_ZERO;
               tick_q <= 1'b0;
               wave_q <= 1'b0;
            end else begin
               cnt_q  <= cnt_d;
               div_q  <= div_d;
               tick_q <= tick_d;
               wave_q <= wave_d;
            end
         end

         assign o_tick[k] = tick_q;
         assign o_wave[k] = wave_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/multi_clk_div.md
Name: multi_clk_div

Overview:
- Parametrised, multi-channel clock-enable generator for the display and timing fabric. It supersedes the fixed single-rate divider.
- Each channel has a run-time programmable divisor. Each channel produces two outputs:
  - a one-cycle tick strobe;
  - a registered square wave with a 50% duty cycle.
- Divisor changes take effect only at a period boundary. A global enable and a phase-align restart are provided.
- Typical use: 1 Hz blink tick plus kHz-range digit-refresh tick from the 100 MHz board clock.

Parameters:
- NUM_CH, 2: number of independent divider channels (>=1).
- CNT_WIDTH, 26: counter and divisor width per channel. 26 bits covers 50_000_000 at 100 MHz.

Ports:
- i_clk, input, 1: system clock (100 MHz on board); all logic on its rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_en, input, 1: global count enable.
- i_sync, input, 1: synchronous restart of all channels (phase alignment).
- i_div, input, NUM_CH*CNT_WIDTH: packed requested divisors; channel k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- o_tick, output, NUM_CH: per-channel one-cycle strobe, once per divisor period.
- o_wave, output, NUM_CH: per-channel square wave, toggles once per divisor period (period 2*D).

Behaviour:
- Reset (async assert, release sync to i_clk): all counters 0, all active divisors 0, o_tick 0, o_wave 0.
- Per-channel state:
  - cnt[CNT_WIDTH]
  - act_div[CNT_WIDTH], the shadow/active divisor
  - registered tick and wave flops
- Channel update priority per rising edge, highest first:
  1. i_sync=1: cnt<=0, wave<=0, tick<=0, act_div<=i_div(k). i_sync overrides i_en.
  2. act_div==0: channel idle. cnt<=0, tick<=0, wave holds, act_div<=i_div(k), sampled every cycle regardless of i_en.
  3. i_en=0: cnt, wave and act_div hold; tick<=0.
  4. cnt==act_div-1, the terminal count:
     - tick<=1, wave<=~wave, cnt<=0;
     - act_div<=i_div(k), so the new divisor takes effect only at the period boundary.
     - If the new i_div(k) is 0, the channel goes idle from the next cycle; wave holds its last level.
  5. Otherwise: cnt<=cnt+1, tick<=0.
- Timing:
  - After the load edge with act_div=D and i_en=1, the first o_tick is high after the D-th subsequent edge.
  - Thereafter o_tick is high for exactly 1 cycle in every D.
  - o_wave period is 2*D cycles, high for D and low for D.
- Boundary cases:
  - D=1: o_tick continuously high while enabled; o_wave = i_clk/2.
  - D=2^CNT_WIDTH-1: counter reaches all-ones-minus-one then wraps to 0; the counter never overflows.
  - i_div changing mid-period: no effect until the terminal count or i_sync.
  - i_en dropped mid-period: count resumes from the held value on re-enable, with no extra or lost tick. Total enabled cycles between ticks equals D.
  - Reset mid-period: immediate clear of all state; outputs low asynchronously.
- Channel independence: channels are fully independent except for the shared i_en and i_sync.
- Arithmetic: unsigned, with the compare done at CNT_WIDTH bits. No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/idle: hold i_rst_n=0 with i_div=4 on ch0, release with i_en=1.
  - Edge 1 loads act_div=4.
  - o_tick[0] is high on edges 5, 9, 13, … (1-cycle pulses).
  - o_wave[0] rises at edge 5, falls at edge 9.
- D=1 and idle: ch0 i_div=1, ch1 i_div=0, i_en=1.
  - o_tick[0] is constant 1 and o_wave[0] toggles every cycle.
  - o_tick[1] and o_wave[1] stay 0.
- Divisor change mid-period: ch0 running with D=4, i_div switched to 6 at cnt=1.
  - The current period still ends after 4 total cycles.
  - Subsequent ticks are spaced 6 cycles apart.
- Enable gating: D=5, i_en low for 7 cycles at cnt=2.
  - No tick and wave stable during the gap.
  - Next tick arrives 3 enabled cycles after re-enable, i.e. 5 enabled cycles between ticks.
- Sync alignment: ch0 D=3, ch1 D=6 free-running out of phase, pulse i_sync for 1 cycle.
  - Both counters and waves clear.
  - The next ticks coincide: ch0 every 3 cycles, ch1 every 6 cycles, every ch1 tick aligned with a ch0 tick.
- Async reset mid-operation: assert i_rst_n=0 between clock edges while o_wave=1.
  - o_wave and o_tick go 0 without waiting for a clock edge.
  - After release, the channel behaves as in the reset/idle scenario.
